// File: rtl/spi_cmd_decoder_pkg.sv
// Shared definitions for the SPI command decoder: state encoding, frame layout constants.
package spi_cmd_decoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ADDR    = 2'd1,
        ST_DATA    = 2'd2,
        ST_WAIT_CS = 2'd3
    } state_e;

    localparam int            RW_BIT           = 7;
    localparam logic [6:0]    LED_ADDR_DEFAULT = 7'h01;
    localparam int            FRAME_BYTES      = 2;
    localparam logic [2:0]    LAST_BIT         = 3'd7;

endpackage

// File: rtl/spi_cmd_decoder_sync.sv
// Multi-stage synchronizer for the asynchronous SPI pins, with rise/fall detect on SCK.
module spi_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic spi_sck,
    input  logic spi_mosi,
    input  logic spi_cs_n,
    output logic sck_rise,
    output logic sck_fall,
    output logic mosi_s,
    output logic cs_n_s
);

    logic [SYNC_STAGES-1:0] sck_q, sck_d;
    logic [SYNC_STAGES-1:0] mosi_q, mosi_d;
    logic [SYNC_STAGES-1:0] cs_n_q, cs_n_d;
    logic                   sck_prev_q, sck_prev_d;

    always_comb begin
        sck_d      = {sck_q[SYNC_STAGES-2:0], spi_sck};
        mosi_d     = {mosi_q[SYNC_STAGES-2:0], spi_mosi};
        cs_n_d     = {cs_n_q[SYNC_STAGES-2:0], spi_cs_n};
        sck_prev_d = sck_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sck_q      <= '0;
            mosi_q     <= '0;
            cs_n_q     <= '1;
            sck_prev_q <= 1'b0;
        end else begin
            sck_q      <= sck_d;
            mosi_q     <= mosi_d;
            cs_n_q     <= cs_n_d;
            sck_prev_q <= sck_prev_d;
        end
    end

    assign sck_rise = sck_q[SYNC_STAGES-1] & ~sck_prev_q;
    assign sck_fall = ~sck_q[SYNC_STAGES-1] & sck_prev_q;
    assign mosi_s   = mosi_q[SYNC_STAGES-1];
    assign cs_n_s   = cs_n_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_cmd_decoder.sv
// Two-byte SPI write-command decoder producing register write / LED strobes.
// Optional SPI_READBACK_EN adds a shadow of the last write, returned on MISO for read frames.
module spi_cmd_decoder
    import spi_cmd_decoder_pkg::*;
#(
    parameter logic [6:0] LED_ADDR    = LED_ADDR_DEFAULT,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_sck,
    input  logic       spi_mosi,
    input  logic       spi_cs_n,
    output logic       spi_miso,
    output logic       wr_en,
    output logic [6:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       led_en,
    output logic       frame_err
);

    logic sck_rise, sck_fall, mosi_s, cs_n_s;

    spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk      (clk),
        .rst      (rst),
        .spi_sck  (spi_sck),
        .spi_mosi (spi_mosi),
        .spi_cs_n (spi_cs_n),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall),
        .mosi_s   (mosi_s),
        .cs_n_s   (cs_n_s)
    );

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       cs_prev_q, cs_prev_d;
    logic       rw_q, rw_d;
    logic [6:0] addr_q, addr_d;
    logic       wr_en_q, wr_en_d;
    logic       led_en_q, led_en_d;
    logic       err_q, err_d;
    logic [6:0] wr_addr_q, wr_addr_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic       miso_q, miso_d;
    logic [7:0] byte_in;

`ifdef SPI_READBACK_EN
    logic [7:0] shadow_q, shadow_d;
    logic [7:0] tx_q, tx_d;
`endif

    assign byte_in = {shift_q[6:0], mosi_s};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        cs_prev_d = cs_n_s;
        rw_d      = rw_q;
        addr_d    = addr_q;
        wr_en_d   = 1'b0;
        err_d     = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        case (state_q)
            ST_IDLE: begin
                if (cs_prev_q && !cs_n_s) begin
                    state_d = ST_ADDR;
                    cnt_d   = 3'd0;
                    shift_d = 8'h00;
                end
            end
            ST_ADDR: begin
                // CS release wins over a coincident SCK edge.
                if (cs_n_s) begin
                    state_d = ST_IDLE;
                    err_d   = (cnt_q != 3'd0);
                end else if (sck_rise) begin
                    shift_d = byte_in;
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == LAST_BIT) begin
                        rw_d    = byte_in[RW_BIT];
                        addr_d  = byte_in[6:0];
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (cs_n_s) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else if (sck_rise) begin
                    shift_d = byte_in;
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == LAST_BIT) begin
                        state_d = ST_WAIT_CS;
                        if (!rw_q) begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = addr_q;
                            wr_data_d = byte_in;
                        end
                    end
                end
            end
            default: begin
                if (cs_n_s) state_d = ST_IDLE;
            end
        endcase
        led_en_d = wr_en_d && (wr_addr_d == LED_ADDR);
    end

`ifdef SPI_READBACK_EN
    always_comb begin
        shadow_d = wr_en_d ? wr_data_d : shadow_q;
        tx_d     = tx_q;
        if (state_q == ST_ADDR && state_d == ST_DATA) begin
            tx_d = shadow_q;
        end else if (state_q == ST_DATA && sck_fall && cnt_q != 3'd0) begin
            // The fall right after the address byte keeps bit 7 on the line.
            tx_d = {tx_q[6:0], 1'b0};
        end
        miso_d = (state_d == ST_DATA) && rw_d && tx_d[7];
    end
`else
    assign miso_d = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 3'd0;
            shift_q   <= 8'h00;
            cs_prev_q <= 1'b1;
            rw_q      <= 1'b0;
            addr_q    <= 7'h00;
            wr_en_q   <= 1'b0;
            led_en_q  <= 1'b0;
            err_q     <= 1'b0;
            wr_addr_q <= 7'h00;
            wr_data_q <= 8'h00;
            miso_q    <= 1'b0;
`ifdef SPI_READBACK_EN
            shadow_q  <= 8'h00;
            tx_q      <= 8'h00;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            cs_prev_q <= cs_prev_d;
            rw_q      <= rw_d;
            addr_q    <= addr_d;
            wr_en_q   <= wr_en_d;
            led_en_q  <= led_en_d;
            err_q     <= err_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            miso_q    <= miso_d;
`ifdef SPI_READBACK_EN
            shadow_q  <= shadow_d;
            tx_q      <= tx_d;
`endif
        end
    end

`ifndef SPI_READBACK_EN
    logic unused_fall;
    assign unused_fall = sck_fall;
`endif

    assign spi_miso  = miso_q;
    assign wr_en     = wr_en_q;
    assign led_en    = led_en_q;
    assign frame_err = err_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Directed bench for spi_cmd_decoder; SCK runs at clk/8, readback expectations follow SPI_READBACK_EN.
module tb_spi_cmd_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       spi_sck = 1'b0;
    logic       spi_mosi = 1'b0;
    logic       spi_cs_n = 1'b1;
    logic       spi_miso;
    logic       wr_en;
    logic [6:0] wr_addr;
    logic [7:0] wr_data;
    logic       led_en;
    logic       frame_err;

    int errors = 0;
    int checks = 0;
    int n_wr = 0, n_led = 0, n_err = 0, n_bad = 0;
    int s_wr, s_led, s_err;
    logic prev_strobe = 1'b0;
    logic [7:0] rx;

    always #5 clk = ~clk;

    spi_cmd_decoder dut (
        .clk       (clk),
        .rst       (rst),
        .spi_sck   (spi_sck),
        .spi_mosi  (spi_mosi),
        .spi_cs_n  (spi_cs_n),
        .spi_miso  (spi_miso),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .led_en    (led_en),
        .frame_err (frame_err)
    );

    // Strobe counters plus protocol sanity: led_en only with wr_en at LED address, no back-to-back strobes.
    always @(negedge clk) begin
        if (wr_en) n_wr++;
        if (led_en) n_led++;
        if (frame_err) n_err++;
        if (led_en && !(wr_en && wr_addr == 7'h01)) n_bad++;
        if ((wr_en || led_en) && prev_strobe) n_bad++;
        prev_strobe = wr_en || led_en;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic snap();
        s_wr = n_wr; s_led = n_led; s_err = n_err;
    endtask

    task automatic send_bits(input logic [7:0] b, input int nbits);
        for (int i = 7; i > 7 - nbits; i--) begin
            spi_mosi = b[i];
            clks(4);
            rx = {rx[6:0], spi_miso};
            spi_sck = 1'b1;
            clks(4);
            spi_sck = 1'b0;
        end
    endtask

    task automatic cs_low();
        spi_cs_n = 1'b0;
        clks(6);
    endtask

    task automatic cs_high();
        clks(4);
        spi_cs_n = 1'b1;
        clks(10);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wr_en"}, wr_en, 1'b0);
        check({tag, "_led_en"}, led_en, 1'b0);
        check({tag, "_frame_err"}, frame_err, 1'b0);
        check({tag, "_wr_addr"}, wr_addr, 7'h00);
        check({tag, "_wr_data"}, wr_data, 8'h00);
        check({tag, "_miso"}, spi_miso, 1'b0);
    endtask

    initial begin
        clks(5);
        check_all_zero("reset");
        rst = 1'b0;
        clks(5);

        // LED write
        snap();
        cs_low(); send_bits(8'h01, 8); send_bits(8'hA5, 8); cs_high();
        check("led_wr_count", n_wr - s_wr, 1);
        check("led_led_count", n_led - s_led, 1);
        check("led_err_count", n_err - s_err, 0);
        check("led_wr_addr", wr_addr, 7'h01);
        check("led_wr_data", wr_data, 8'hA5);

        // Non-LED write
        snap();
        cs_low(); send_bits(8'h02, 8); send_bits(8'h3C, 8); cs_high();
        check("other_wr_count", n_wr - s_wr, 1);
        check("other_led_count", n_led - s_led, 0);
        check("other_wr_addr", wr_addr, 7'h02);
        check("other_wr_data", wr_data, 8'h3C);

        // Abort after 5 data bits
        snap();
        cs_low(); send_bits(8'h01, 8); send_bits(8'hFF, 5); cs_high();
        check("abort_wr_count", n_wr - s_wr, 0);
        check("abort_err_count", n_err - s_err, 1);
        check("abort_wr_data_held", wr_data, 8'h3C);
        snap();
        cs_low(); send_bits(8'h01, 8); send_bits(8'h0F, 8); cs_high();
        check("post_abort_wr_count", n_wr - s_wr, 1);
        check("post_abort_wr_data", wr_data, 8'h0F);
        check("post_abort_err_count", n_err - s_err, 0);

        // Extra byte in the same CS window is ignored
        snap();
        cs_low(); send_bits(8'h01, 8); send_bits(8'h55, 8); send_bits(8'hFF, 8); cs_high();
        check("long_led_count", n_led - s_led, 1);
        check("long_wr_count", n_wr - s_wr, 1);
        check("long_wr_data", wr_data, 8'h55);
        check("long_err_count", n_err - s_err, 0);

        // Readback of last write
        cs_low(); send_bits(8'h01, 8); send_bits(8'hC3, 8); cs_high();
        snap();
        rx = 8'h00;
        cs_low(); send_bits(8'h81, 8); rx = 8'h00; send_bits(8'h00, 8); cs_high();
`ifdef SPI_READBACK_EN
        check("read_miso_byte", rx, 8'hC3);
`else
        check("read_miso_byte", rx, 8'h00);
`endif
        check("read_wr_count", n_wr - s_wr, 0);
        check("read_led_count", n_led - s_led, 0);
        check("read_wr_data", wr_data, 8'hC3);
        check("read_miso_idle", spi_miso, 1'b0);

        // CS pulse without clocks: silent
        snap();
        cs_low(); cs_high();
        check("empty_err_count", n_err - s_err, 0);
        check("empty_wr_count", n_wr - s_wr, 0);

        // Reset in the middle of the address byte
        snap();
        cs_low(); send_bits(8'h01, 4);
        rst = 1'b1;
        clks(3);
        check_all_zero("midrst");
        rst = 1'b0;
        clks(2);
        spi_cs_n = 1'b1;
        clks(10);
        check("midrst_wr_count", n_wr - s_wr, 0);
        check("midrst_err_count", n_err - s_err, 0);
        snap();
        cs_low(); send_bits(8'h01, 8); send_bits(8'h77, 8); cs_high();
        check("after_rst_wr_count", n_wr - s_wr, 1);
        check("after_rst_led_count", n_led - s_led, 1);
        check("after_rst_wr_data", wr_data, 8'h77);
        check("after_rst_wr_addr", wr_addr, 7'h01);

        check("strobe_rules", n_bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_cmd_decoder.md
SPI_CMD_DECODER -- requirements
Module: spi_cmd_decoder

Interface
REQ-001 Parameter: LED_ADDR, 7'h01, register address whose writes raise led_en.
REQ-002 Parameter: SYNC_STAGES, 2, synchronizer depth for spi_sck/spi_mosi/spi_cs_n (legal 2..3).
REQ-003 clk  in  1  system clock; all state on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 spi_sck  in  1  SPI clock from MCU, asynchronous, mode 0, f_sck <= f_clk/8.
REQ-006 spi_mosi  in  1  SPI data in, MSB first, sampled on synchronized SCK rising edge.
REQ-007 spi_cs_n  in  1  SPI chip select, active-low, asynchronous.
REQ-008 spi_miso  out  1  SPI data out (see Configuration).
REQ-009 wr_en  out  1  one-cycle write strobe, any address.
REQ-010 wr_addr  out  7  address of current/last write, held until next write.
REQ-011 wr_data  out  8  data of current/last write, held until next write.
REQ-012 led_en  out  1  one-cycle strobe, wr_en AND wr_addr==LED_ADDR; drives LED controller enable, wr_data drives its data.
REQ-013 frame_err  out  1  one-cycle pulse on aborted frame.

Function
REQ-014 Inputs pass through SYNC_STAGES flops; edges detected by comparing last two synchronized SCK samples.
REQ-015 Frame = CS low, byte 0 = {rw, addr[6:0]} (rw=0 write, 1 read), byte 1 = data.
REQ-016 FSM states: IDLE, ADDR, DATA, WAIT_CS.
REQ-017 IDLE -> ADDR on synchronized CS falling; bit counter and shift register cleared.
REQ-018 ADDR -> DATA after 8th SCK rising edge; rw and addr latched.
REQ-019 DATA -> WAIT_CS after 8th SCK rising edge; for rw=0, wr_en asserted exactly one clk after the cycle sampling bit 0, with wr_addr/wr_data valid same cycle.
REQ-020 rw=1 frames produce no wr_en/led_en.
REQ-021 WAIT_CS: further SCK edges ignored; -> IDLE on synchronized CS high.
REQ-022 CS high in ADDR or DATA with bit count 1..7 or in DATA with count 0: abort, no strobe, frame_err pulses one clk, -> IDLE; CS high in ADDR with count 0 -> IDLE, no frame_err.
REQ-023 CS high and SCK rising edge in same synchronized cycle: CS takes priority, edge discarded.
REQ-024 Bit counter 3 bits, wraps 7->0 at byte boundary.
REQ-025 led_en and wr_en never asserted in consecutive cycles.

Reset
REQ-026 rst forces IDLE, counter 0, shift register 0, wr_en=0, led_en=0, frame_err=0, wr_addr=0, wr_data=0, spi_miso=0, synchronizer flops to idle levels (sck 0, cs_n 1, mosi 0).
REQ-027 rst mid-frame discards frame, no strobe, no frame_err; decoding resumes only after next CS falling edge.

Configuration
REQ-028 Macro SPI_READBACK_EN defined: 8-bit shadow register loads wr_data on each wr_en; during DATA of rw=1 frame spi_miso presents shadow MSB-first, bit 7 valid before first SCK rising edge, next bit updated on each synchronized SCK falling edge; 0 otherwise; shadow resets to 0.
REQ-029 SPI_READBACK_EN undefined: spi_miso constant 0, no shadow register, read frames consumed silently.

Structure
REQ-030 Shared package holds FSM state encoding, rw bit position, default LED_ADDR, frame length constant (2 bytes).
REQ-031 Sub-module spi_sync: SYNC_STAGES-deep synchronizer plus rise/fall edge detect for sck, plain sync for mosi/cs_n.

Verification
REQ-032 Write frame 8'h01, 8'hA5, f_sck=f_clk/8 -> single wr_en+led_en pulse, wr_addr=7'h01, wr_data=8'hA5, frame_err=0.
REQ-033 Write frame 8'h02, 8'h3C -> wr_en pulse, wr_addr=7'h02, wr_data=8'h3C, led_en stays 0.
REQ-034 CS raised after 5 bits of data byte -> no wr_en, frame_err one pulse, next frame 8'h01, 8'h0F writes 8'h0F.
REQ-035 Frame 8'h01, 8'h55, 8'hFF in one CS window -> exactly one led_en, wr_data=8'h55.
REQ-036 With SPI_READBACK_EN: write 8'h01/8'hC3 then read 8'h81 -> MISO returns 8'hC3, no strobe; without macro MISO stays 0.
REQ-037 rst asserted mid-address-byte -> all outputs 0, next complete write frame accepted normally.
